// File: rtl/regfile_pkg.sv
// Shared constants and request type for the register-file write-back path.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_queue_dec.sv
// 5-to-32 decoder producing the raw register write enable for the queue head.
module dec_5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    assign onehot_o = NUM_REGS'(1) << addr_i;

endmodule

// File: rtl/regfile_wr_queue.sv
// Write-back queue ahead of the register array: buffers writes, retires one per
// cycle and forwards pending data to both read ports.
module regfile_wr_queue #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     hold,
    output logic                     commit_en,
    output logic [31:0]              commit_onehot,
    output logic [DATA_W-1:0]        commit_data,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic                     fwd_hit_a,
    output logic                     fwd_hit_b,
    output logic [DATA_W-1:0]        fwd_data_a,
    output logic [DATA_W-1:0]        fwd_data_b,
    output logic [$clog2(DEPTH):0]   count
);
    import regfile_pkg::wr_req_t;
    import regfile_pkg::ZERO_REG;
    import regfile_pkg::NUM_REGS;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wr_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic [NUM_REGS-1:0] dec_onehot;

    assign wr_ready  = !reset && (count_q < DEPTH_C);
    // Writes to the zero register complete the handshake but never occupy a slot.
    assign push      = wr_valid && wr_ready && (wr_addr != ZERO_REG);
    assign commit_en = (count_q != '0) && !hold && !reset;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        if (push)      tail_d = tail_q + PTR_W'(1);
        if (commit_en) head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(commit_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q].addr <= wr_addr;
            mem_q[tail_q].data <= wr_data;
        end
    end

    dec_5to32 u_dec (
        .addr_i   (mem_q[head_q].addr),
        .onehot_o (dec_onehot)
    );

    assign commit_onehot = dec_onehot & {NUM_REGS{commit_en}};
    assign commit_data   = commit_en ? mem_q[head_q].data : '0;

    // Entries viewed by age: offset 0 is the head (oldest), higher offsets are younger.
    wr_req_t          ent [DEPTH];
    logic [DEPTH-1:0] hit_a, hit_b;

    for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
        logic [PTR_W-1:0] slot;
        logic             live;
        assign slot     = head_q + PTR_W'(k);
        assign ent[k]   = mem_q[slot];
        assign live     = CNT_W'(k) < count_q;
        assign hit_a[k] = live && (ent[k].addr == rd_addr_a);
        assign hit_b[k] = live && (ent[k].addr == rd_addr_b);
    end

    // Ascending scan with overwrite leaves the youngest match in place.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!reset && rd_addr_a != ZERO_REG && hit_a[k]) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = ent[k].data;
            end
            if (!reset && rd_addr_b != ZERO_REG && hit_b[k]) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = ent[k].data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_queue.sv
// Self-checking bench for regfile_wr_queue: directed scenarios plus a random
// run against a queue-based reference model.
module tb_regfile_wr_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, wr_valid, wr_ready, hold, commit_en;
    logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [63:0] wr_data, commit_data, fwd_data_a, fwd_data_b;
    logic [31:0] commit_onehot;
    logic        fwd_hit_a, fwd_hit_b;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    wr_req_t mq[$];

    always #5 clk = ~clk;

    regfile_wr_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold),
        .commit_en(commit_en), .commit_onehot(commit_onehot), .commit_data(commit_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .count(count)
    );

    function automatic logic exp_ready();
        return !reset && mq.size() < DEPTH;
    endfunction

    function automatic logic exp_commit();
        return mq.size() != 0 && !hold && !reset;
    endfunction

    function automatic logic [31:0] exp_onehot();
        return exp_commit() ? (32'd1 << mq[0].addr) : 32'd0;
    endfunction

    function automatic logic [63:0] exp_cdata();
        return exp_commit() ? mq[0].data : 64'd0;
    endfunction

    // {hit, data}: newest queued write to the address wins.
    function automatic logic [64:0] exp_fwd(input logic [4:0] ra);
        if (reset || ra == 5'd31) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr == ra) return {1'b1, mq[i].data};
        return '0;
    endfunction

    // Advance one clock and update the model from the inputs held over the edge.
    task automatic tick();
        logic    pop, psh;
        wr_req_t e;
        pop = exp_commit();
        psh = wr_valid && exp_ready() && wr_addr != 5'd31;
        e.addr = wr_addr;
        e.data = wr_data;
        @(posedge clk);
        if (reset) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (psh) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        drive(1'b0, 5'd0, 64'd0);
        tick();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", wr_ready); end
        checks++; if (commit_en !== 1'b0 || commit_onehot !== 32'd0 || commit_data !== 64'd0) begin
            errors++; $display("FAIL reset_commit got en=%b oh=%h d=%h want 0", commit_en, commit_onehot, commit_data); end
        checks++; if (count !== 2'd0 || fwd_hit_a !== 1'b0 || fwd_data_a !== 64'd0) begin
            errors++; $display("FAIL reset_state got cnt=%0d hit=%b fd=%h want 0", count, fwd_hit_a, fwd_data_a); end
        reset = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 64'hDEAD_BEEF);
        #1;
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL single_pre got en=%b want 0", commit_en); end
        tick();
        drive(1'b0, 5'd0, 64'd0);
        rd_addr_a = 5'd5;
        #1;
        checks++; if (commit_en !== 1'b1 || commit_onehot !== 32'h0000_0020 || commit_data !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL single_commit got en=%b oh=%h d=%h want 1/00000020/deadbeef", commit_en, commit_onehot, commit_data); end
        checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL single_fwd got hit=%b d=%h want 1/deadbeef", fwd_hit_a, fwd_data_a); end
        tick();
        checks++; if (count !== 2'd0 || commit_en !== 1'b0) begin
            errors++; $display("FAIL single_drain got cnt=%0d en=%b want 0/0", count, commit_en); end
    endtask

    task automatic test_backpressure();
        hold = 1'b1;
        drive(1'b1, 5'd1, 64'h1111); tick();
        drive(1'b1, 5'd2, 64'h2222); tick();
        drive(1'b1, 5'd3, 64'h3333);
        #1;
        checks++; if (count !== 2'd2 || wr_ready !== 1'b0 || commit_en !== 1'b0) begin
            errors++; $display("FAIL bp_full got cnt=%0d rdy=%b en=%b want 2/0/0", count, wr_ready, commit_en); end
        tick();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_stall got cnt=%0d want 2", count); end
        hold = 1'b0;
        #1;
        checks++; if (commit_onehot !== 32'h2 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL bp_first got oh=%h rdy=%b want 00000002/0", commit_onehot, wr_ready); end
        tick();
        checks++; if (commit_onehot !== 32'h4 || commit_data !== 64'h2222 || wr_ready !== 1'b1 || count !== 2'd1) begin
            errors++; $display("FAIL bp_second got oh=%h d=%h rdy=%b cnt=%0d want 00000004/2222/1/1", commit_onehot, commit_data, wr_ready, count); end
        tick();
        drive(1'b0, 5'd0, 64'd0);
        #1;
        checks++; if (commit_onehot !== 32'h8 || commit_data !== 64'h3333 || count !== 2'd1) begin
            errors++; $display("FAIL bp_third got oh=%h d=%h cnt=%0d want 00000008/3333/1", commit_onehot, commit_data, count); end
        tick();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd31, 64'hBAD);
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL x31_ready got %b want 1", wr_ready); end
        tick();
        drive(1'b0, 5'd0, 64'd0);
        rd_addr_a = 5'd31;
        #1;
        checks++; if (count !== 2'd0 || commit_en !== 1'b0 || fwd_hit_a !== 1'b0) begin
            errors++; $display("FAIL x31_drop got cnt=%0d en=%b hit=%b want 0/0/0", count, commit_en, fwd_hit_a); end
        tick();
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL x31_late got en=%b want 0", commit_en); end
    endtask

    task automatic test_fwd_priority();
        hold = 1'b1;
        drive(1'b1, 5'd7, 64'h11); tick();
        drive(1'b1, 5'd7, 64'h22); tick();
        drive(1'b0, 5'd0, 64'd0);
        rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
        checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22 || fwd_data_b !== 64'h22) begin
            errors++; $display("FAIL fwd_young got hit=%b a=%h b=%h want 1/22/22", fwd_hit_a, fwd_data_a, fwd_data_b); end
        hold = 1'b0;
        tick();
        checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22 || count !== 2'd1) begin
            errors++; $display("FAIL fwd_after_pop got hit=%b d=%h cnt=%0d want 1/22/1", fwd_hit_a, fwd_data_a, count); end
        tick();
        checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 64'd0) begin
            errors++; $display("FAIL fwd_gone got hit=%b d=%h want 0/0", fwd_hit_a, fwd_data_a); end
    endtask

    task automatic test_stream();
        logic [63:0] d [6];
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d[i] = {$urandom, $urandom};
            drive(1'b1, 5'(i), d[i]);
            #1;
            checks++; if (count > 2'd1 || wr_ready !== 1'b1) begin
                errors++; $display("FAIL stream_cnt[%0d] got cnt=%0d rdy=%b want <=1/1", i, count, wr_ready); end
            if (i > 0) begin
                checks++; if (commit_onehot !== (32'd1 << (i - 1)) || commit_data !== d[i-1]) begin
                    errors++; $display("FAIL stream_commit[%0d] got oh=%h d=%h want %h/%h", i, commit_onehot, commit_data, 32'd1 << (i - 1), d[i-1]); end
            end
            tick();
        end
        drive(1'b0, 5'd0, 64'd0);
        #1;
        checks++; if (commit_onehot !== 32'h20 || commit_data !== d[5]) begin
            errors++; $display("FAIL stream_last got oh=%h d=%h want 00000020/%h", commit_onehot, commit_data, d[5]); end
        tick();
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        drive(1'b1, 5'd9, 64'h99); tick();
        drive(1'b1, 5'd10, 64'hAA); tick();
        drive(1'b0, 5'd0, 64'd0);
        hold = 1'b0; reset = 1'b1; rd_addr_a = 5'd9;
        #1;
        checks++; if (commit_en !== 1'b0 || wr_ready !== 1'b0 || fwd_hit_a !== 1'b0) begin
            errors++; $display("FAIL rstmid_cycle got en=%b rdy=%b hit=%b want 0/0/0", commit_en, wr_ready, fwd_hit_a); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (count !== 2'd0 || wr_ready !== 1'b1 || commit_en !== 1'b0 || fwd_hit_a !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got cnt=%0d rdy=%b en=%b hit=%b want 0/1/0/0", count, wr_ready, commit_en, fwd_hit_a); end
    endtask

    task automatic test_random();
        logic [64:0] fa, fb;
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) < 2);
            hold      = ($urandom_range(0, 99) < 30);
            drive($urandom_range(0, 99) < 70,
                  ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                  {$urandom, $urandom});
            rd_addr_a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 7));
            #1;
            fa = exp_fwd(rd_addr_a);
            fb = exp_fwd(rd_addr_b);
            checks++; if (wr_ready !== exp_ready() || count !== 2'(mq.size())) begin
                errors++; $display("FAIL rnd_state[%0d] got rdy=%b cnt=%0d want %b/%0d", n, wr_ready, count, exp_ready(), mq.size()); end
            checks++; if (commit_en !== exp_commit() || commit_onehot !== exp_onehot() || commit_data !== exp_cdata()) begin
                errors++; $display("FAIL rnd_commit[%0d] got en=%b oh=%h d=%h want %b/%h/%h", n, commit_en, commit_onehot, commit_data, exp_commit(), exp_onehot(), exp_cdata()); end
            checks++; if ({fwd_hit_a, fwd_data_a} !== fa || {fwd_hit_b, fwd_data_b} !== fb) begin
                errors++; $display("FAIL rnd_fwd[%0d] got a=%b/%h b=%b/%h want %b/%h %b/%h", n, fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b, fa[64], fa[63:0], fb[64], fb[63:0]); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_zero_reg();
        test_fwd_priority();
        test_stream();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
